hd44780_bus_receiver: RTL and testbench
=======================================

Name: hd44780_bus_receiver

Overview:
- Receiving end of the 16x2 HD44780 parallel LCD bus that the game's LCD driver writes to.
- Captures E-strobed writes, decodes instructions and data, and keeps a 32-cell shadow of the visible display plus cursor and mode state.
- Used as an on-chip bus monitor for debug readout and as a self-checking sink in system simulation.

Parameters:
- SYNC_STAGES, 2, synchroniser depth on lcd_e/lcd_rs/lcd_rw/lcd_data (min 2).
- E_MIN_HIGH, 4, minimum synchronised E-high width in clk cycles; shorter pulses are runts.
- MIN_GAP_CYCLES, 2000, minimum clk cycles between accepted strobes (40 us at 50 MHz); used only by the optional feature.

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  asynchronous, active-high reset
- lcd_rs  in  1  register select: 0 = instruction, 1 = data
- lcd_rw  in  1  1 = read cycle
- lcd_e  in  1  enable strobe; bus is latched on its falling edge
- lcd_data  in  8  bus data
- rd_addr  in  5  shadow cell index: 0-15 row 0, 16-31 row 1
- rd_char  out  8  shadow cell content, registered
- cursor_addr  out  7  current DDRAM address
- display_on  out  1  D bit from the last display-control instruction
- busy  out  1  high while a clear is in progress
- cmd_valid  out  1  one-cycle pulse per accepted write
- cmd_rs  out  1  rs of the accepted write
- cmd_byte  out  8  data of the accepted write
- overrun  out  1  sticky; strobe arrived while busy
- timing_err  out  8  saturating gap-violation count

Behaviour:
- Reset (async): every shadow cell = 0x20; cursor_addr = 0x00; increment mode; DDRAM mode; display_on = 0; busy = 0; cmd_valid = 0; cmd_rs = 0; cmd_byte = 0; overrun = 0; timing_err = 0; rd_char = 0x20.
- Bus capture: all bus inputs pass through SYNC_STAGES flops. While synchronised E = 1, a width counter runs and rs/rw/data are held every cycle.
- Strobe: a falling edge of synchronised E with width >= E_MIN_HIGH is a strobe. A runt (width < E_MIN_HIGH) is ignored entirely, with no state change.
- rw = 1 strobe: ignored, no cmd_valid.
- Strobe while busy: dropped; overrun set to 1.
- Otherwise the write is accepted and cmd_valid/cmd_rs/cmd_byte are asserted the cycle after the falling edge. Decode takes effect in that same cycle.
- Instruction decode, rs = 0, highest set bit wins:
  - 1xxxxxxx: DDRAM set; cursor_addr = byte[6:0]; enter DDRAM mode.
  - 01xxxxxx: CGRAM set; enter CGRAM mode.
  - 001xxxxx: function set; no effect.
  - 0001 S/C R/L xx: if S/C = 0, move the cursor by one in direction R/L (1 = right, +1); if S/C = 1, no effect.
  - 00001DCB: display_on = D.
  - 000001 I/D S: increment mode = I/D; S is ignored.
  - 0000001x: cursor_addr = 0x00.
  - 00000001: clear.
- Clear: busy = 1 for exactly 32 cycles and writes 0x20 to cells 0..31, one cell per cycle. On completion cursor_addr = 0x00, increment mode, DDRAM mode, busy = 0.
- Data, rs = 1, in DDRAM mode:
  - If cursor_addr is 0x00-0x0F, write cell = cursor_addr.
  - If cursor_addr is 0x40-0x4F, write cell = 16 + cursor_addr[3:0].
  - Any other address: write discarded.
  - Then step the cursor.
- Data, rs = 1, in CGRAM mode: discarded; cursor_addr unchanged.
- Cursor step:
  - Increment sequence: 0x00..0x27 then 0x40; 0x40..0x67 then 0x00.
  - Decrement is the exact inverse: 0x00 -> 0x67, 0x40 -> 0x27.
  - DDRAM-set values outside 0x00-0x27 and 0x40-0x67 are loaded as-is; the next step from such a value goes to 0x00.
- Readout: rd_char = cell[rd_addr], one cycle of latency. During a clear it returns the partially-cleared contents.
- If a shadow write and a clear would target the same cycle, the clear wins; this cannot arise because strobes are dropped while busy.

Optional Feature:
- Macro: LCD_RX_TIMING_CHECK_EN.
- Defined: a gap counter restarts at each accepted strobe. If the next accepted strobe comes fewer than MIN_GAP_CYCLES after the previous one, timing_err increments, saturating at 255. The write is still processed normally. The first strobe after reset is never a violation.
- Undefined: no counter is built and timing_err is tied to 0.

Test Plan:
- Reset, then read rd_addr 0..31 -> every rd_char = 0x20; cursor_addr = 0x00; display_on = 0; busy = 0.
- Instruction 0x0C, then 0x80, then data 0x41 and 0x42 -> display_on = 1; cells 0,1 = 0x41,0x42; cursor_addr = 0x02; four cmd_valid pulses with matching cmd_rs/cmd_byte.
- Instruction 0x8F, then data 0x58 and 0x59 -> cell 15 = 0x58; 0x59 discarded; cursor_addr = 0x11. Then 0xA7 and one data write -> cursor_addr = 0x40. Then 0x04 and one data write at 0x40 -> cell 16 written; cursor_addr = 0x27.
- With cells populated, instruction 0x01 -> busy high exactly 32 cycles; all cells 0x20. A data strobe issued mid-clear -> dropped, overrun = 1, no cmd_valid.
- E high for 2 cycles with data 0x41, rs = 1 -> no cmd_valid; shadow and cursor unchanged. Strobe with rw = 1 -> ignored likewise.
- Macro defined: two accepted writes 100 cycles apart -> timing_err = 1. A third write 2500 cycles later -> timing_err stays 1.

Source files
------------

// File: rtl/hd44780_bus_receiver.sv
// hd44780_bus_receiver: HD44780 write-bus monitor keeping a 32-cell shadow of the 16x2 display.
// Define LCD_RX_TIMING_CHECK_EN to count accepted strobes closer than MIN_GAP_CYCLES apart.
module hd44780_bus_receiver #(
    parameter int SYNC_STAGES    = 2,
    parameter int E_MIN_HIGH     = 4,
    parameter int MIN_GAP_CYCLES = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_e,
    input  logic [7:0] lcd_data,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_char,
    output logic [6:0] cursor_addr,
    output logic       display_on,
    output logic       busy,
    output logic       cmd_valid,
    output logic       cmd_rs,
    output logic [7:0] cmd_byte,
    output logic       overrun,
    output logic [7:0] timing_err
);
    localparam int WW = $clog2(E_MIN_HIGH + 1);

    logic [10:0]   sync_q [SYNC_STAGES];
    logic          e_s, rs_s, rw_s, e_d;
    logic [7:0]    data_s;
    logic [WW-1:0] width;
    logic          h_rs, h_rw;
    logic [7:0]    h_data;
    logic          strobe, accept;
    logic          inc_mode, ddram_mode;
    logic [4:0]    clr_idx;
    logic [7:0]    cells [32];

    assign {e_s, rs_s, rw_s, data_s} = sync_q[SYNC_STAGES-1];
    assign strobe = e_d && !e_s && 32'(width) >= E_MIN_HIGH;
    assign accept = strobe && !h_rw && !busy;

    // Visible DDRAM walk: row 0 is 0x00-0x27, row 1 is 0x40-0x67, wrapping between them.
    function automatic logic [6:0] step(input logic [6:0] a, input logic up);
        if (up)
            return (a <= 7'h26 || (a >= 7'h40 && a <= 7'h66)) ? a + 7'd1 : (a == 7'h27) ? 7'h40 : 7'h00;
        return ((a >= 7'h01 && a <= 7'h27) || (a >= 7'h41 && a <= 7'h67)) ? a - 7'd1 :
               (a == 7'h00) ? 7'h67 : (a == 7'h40) ? 7'h27 : 7'h00;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            e_d    <= 1'b0;
            width  <= '0;
            h_rs   <= 1'b0;
            h_rw   <= 1'b0;
            h_data <= '0;
        end else begin
            sync_q[0] <= {lcd_e, lcd_rs, lcd_rw, lcd_data};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            e_d   <= e_s;
            width <= !e_s ? '0 : (32'(width) < E_MIN_HIGH) ? width + WW'(1) : width;
            if (e_s) begin
                h_rs   <= rs_s;
                h_rw   <= rw_s;
                h_data <= data_s;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) cells[i] <= 8'h20;
            cursor_addr <= '0;
            inc_mode    <= 1'b1;
            ddram_mode  <= 1'b1;
            display_on  <= 1'b0;
            busy        <= 1'b0;
            clr_idx     <= '0;
            cmd_valid   <= 1'b0;
            cmd_rs      <= 1'b0;
            cmd_byte    <= '0;
            overrun     <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            if (strobe && !h_rw && busy) overrun <= 1'b1;
            if (busy) begin
                cells[clr_idx] <= 8'h20;
                clr_idx        <= clr_idx + 5'd1;
                if (clr_idx == 5'd31) begin
                    busy        <= 1'b0;
                    cursor_addr <= '0;
                    inc_mode    <= 1'b1;
                    ddram_mode  <= 1'b1;
                end
            end else if (accept) begin
                cmd_valid <= 1'b1;
                cmd_rs    <= h_rs;
                cmd_byte  <= h_data;
                if (h_rs) begin
                    if (ddram_mode) begin
                        if (cursor_addr[6:4] == 3'b000) cells[{1'b0, cursor_addr[3:0]}] <= h_data;
                        else if (cursor_addr[6:4] == 3'b100) cells[{1'b1, cursor_addr[3:0]}] <= h_data;
                        cursor_addr <= step(cursor_addr, inc_mode);
                    end
                end else if (h_data[7]) begin
                    cursor_addr <= h_data[6:0];
                    ddram_mode  <= 1'b1;
                end else if (h_data[6]) begin
                    ddram_mode <= 1'b0;
                end else if (h_data[5:4] == 2'b01) begin
                    if (!h_data[3]) cursor_addr <= step(cursor_addr, h_data[2]);
                end else if (h_data[5:3] == 3'b001) begin
                    display_on <= h_data[2];
                end else if (h_data[5:2] == 4'b0001) begin
                    inc_mode <= h_data[1];
                end else if (h_data[5:1] == 5'b00001) begin
                    cursor_addr <= '0;
                end else if (h_data[5:0] == 6'b000001) begin
                    busy    <= 1'b1;
                    clr_idx <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_char <= 8'h20;
        else rd_char <= cells[rd_addr];
    end

`ifdef LCD_RX_TIMING_CHECK_EN
    localparam int GW = $clog2(MIN_GAP_CYCLES + 1);

    logic [GW-1:0] gap;
    logic          seen;

    // gap holds (distance - 1) to the previous accepted strobe, saturating once legal.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap        <= '0;
            seen       <= 1'b0;
            timing_err <= '0;
        end else if (accept) begin
            gap  <= '0;
            seen <= 1'b1;
            if (seen && 32'(gap) < MIN_GAP_CYCLES - 1 && timing_err != 8'hFF)
                timing_err <= timing_err + 8'd1;
        end else if (32'(gap) < MIN_GAP_CYCLES) begin
            gap <= gap + GW'(1);
        end
    end
`else
    assign timing_err = 8'h00;
`endif
endmodule

// File: tb/tb_hd44780_bus_receiver.sv
// tb_hd44780_bus_receiver: directed checks of the HD44780 bus receiver shadow, decode and clear.
module tb_hd44780_bus_receiver;
    logic       clk = 1'b0, rst = 1'b1;
    logic       lcd_rs = 1'b0, lcd_rw = 1'b0, lcd_e = 1'b0;
    logic [7:0] lcd_data = '0;
    logic [4:0] rd_addr = '0;
    logic [7:0] rd_char, cmd_byte, timing_err;
    logic [6:0] cursor_addr;
    logic       display_on, busy, cmd_valid, cmd_rs, overrun;
    int         n_checks = 0, n_pass = 0;

    hd44780_bus_receiver dut (
        .clk(clk), .rst(rst), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
        .lcd_data(lcd_data), .rd_addr(rd_addr), .rd_char(rd_char),
        .cursor_addr(cursor_addr), .display_on(display_on), .busy(busy),
        .cmd_valid(cmd_valid), .cmd_rs(cmd_rs), .cmd_byte(cmd_byte),
        .overrun(overrun), .timing_err(timing_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic bus_write(input logic rs, input logic rw, input logic [7:0] d, input int hi,
                             output int pulses, output logic prs, output logic [7:0] pb);
        pulses = 0;
        prs    = 1'b0;
        pb     = '0;
        @(negedge clk);
        lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_e = 1'b1;
        repeat (hi) @(negedge clk);
        lcd_e = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (cmd_valid) begin
                pulses++;
                prs = cmd_rs;
                pb  = cmd_byte;
            end
        end
    endtask

    task automatic wr(input logic rs, input logic [7:0] d);
        int         p;
        logic       r;
        logic [7:0] b;
        bus_write(rs, 1'b0, d, 6, p, r, b);
        check($sformatf("pulses_%0d_%02h", rs, d), p, 1);
        check($sformatf("cmd_rs_%02h", d), r, rs);
        check($sformatf("cmd_byte_%02h", d), b, d);
    endtask

    task automatic read_cell(input logic [4:0] a, output logic [7:0] c);
        @(negedge clk);
        rd_addr = a;
        @(negedge clk);
        c = rd_char;
    endtask

    task automatic issue_clear();
        @(negedge clk);
        lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_data = 8'h01; lcd_e = 1'b1;
        repeat (6) @(negedge clk);
        lcd_e = 1'b0;
    endtask

    initial begin
        logic [7:0] c;
        int         p, cyc, pulses_mid;
        logic       r, seen;
        logic [7:0] b;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_rd_char", rd_char, 8'h20);
        check("rst_cursor", cursor_addr, 7'h00);
        check("rst_display_on", display_on, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_cmd_valid", cmd_valid, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_timing_err", timing_err, 8'h00);
        for (int i = 0; i < 32; i++) begin
            read_cell(5'(i), c);
            check($sformatf("rst_cell%0d", i), c, 8'h20);
        end

        wr(1'b0, 8'h0C);
        check("display_on", display_on, 1'b1);
        wr(1'b0, 8'h80);
        wr(1'b1, 8'h41);
        wr(1'b1, 8'h42);
        read_cell(5'd0, c); check("cell0", c, 8'h41);
        read_cell(5'd1, c); check("cell1", c, 8'h42);
        check("cursor_02", cursor_addr, 7'h02);

        wr(1'b0, 8'h8F);
        wr(1'b1, 8'h58);
        wr(1'b1, 8'h59);
        read_cell(5'd15, c); check("cell15", c, 8'h58);
        read_cell(5'd16, c); check("cell16_untouched", c, 8'h20);
        check("cursor_11", cursor_addr, 7'h11);
        wr(1'b0, 8'hA7);
        wr(1'b1, 8'h5A);
        check("cursor_27_to_40", cursor_addr, 7'h40);
        wr(1'b0, 8'h04);
        wr(1'b1, 8'h33);
        read_cell(5'd16, c); check("cell16", c, 8'h33);
        check("cursor_dec_40_to_27", cursor_addr, 7'h27);
        wr(1'b0, 8'h14);
        check("shift_right_27_to_40", cursor_addr, 7'h40);
        wr(1'b0, 8'h10);
        check("shift_left_40_to_27", cursor_addr, 7'h27);
        wr(1'b0, 8'h18);
        check("display_shift_noop", cursor_addr, 7'h27);
        wr(1'b0, 8'h02);
        check("home", cursor_addr, 7'h00);
        wr(1'b0, 8'h10);
        check("shift_left_00_to_67", cursor_addr, 7'h67);
        wr(1'b0, 8'h06);
        wr(1'b0, 8'h14);
        check("shift_right_67_to_00", cursor_addr, 7'h00);
        wr(1'b0, 8'h40);
        wr(1'b1, 8'h77);
        check("cgram_cursor_hold", cursor_addr, 7'h00);
        read_cell(5'd0, c); check("cgram_data_discarded", c, 8'h41);

        issue_clear();
        cyc  = 0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !(seen && !busy); i++) begin
            @(negedge clk);
            if (busy) begin
                seen = 1'b1;
                cyc++;
            end
        end
        check("clear_busy_cycles", cyc, 32);
        check("clear_cursor", cursor_addr, 7'h00);
        for (int i = 0; i < 32; i++) begin
            read_cell(5'(i), c);
            check($sformatf("clr_cell%0d", i), c, 8'h20);
        end

        wr(1'b1, 8'h55);
        read_cell(5'd0, c); check("after_clear_inc", c, 8'h55);
        check("after_clear_cursor", cursor_addr, 7'h01);
        issue_clear();
        for (int i = 0; i < 20 && !busy; i++) @(negedge clk);
        check("clear2_busy", busy, 1'b1);
        lcd_rs = 1'b1; lcd_data = 8'h41; lcd_e = 1'b1;
        repeat (5) @(negedge clk);
        lcd_e = 1'b0;
        pulses_mid = 0;
        for (int i = 0; i < 100 && busy; i++) begin
            @(negedge clk);
            if (cmd_valid) pulses_mid++;
        end
        repeat (4) @(negedge clk);
        check("midclear_no_cmd", pulses_mid, 0);
        check("midclear_overrun", overrun, 1'b1);
        check("midclear_cursor", cursor_addr, 7'h00);
        read_cell(5'd0, c); check("midclear_cell0", c, 8'h20);

        bus_write(1'b1, 1'b0, 8'h41, 2, p, r, b);
        check("runt_no_cmd", p, 0);
        read_cell(5'd0, c); check("runt_cell0", c, 8'h20);
        check("runt_cursor", cursor_addr, 7'h00);
        bus_write(1'b1, 1'b1, 8'h41, 6, p, r, b);
        check("rw_no_cmd", p, 0);
        read_cell(5'd0, c); check("rw_cell0", c, 8'h20);
        check("rw_cursor", cursor_addr, 7'h00);
        bus_write(1'b1, 1'b0, 8'h37, 4, p, r, b);
        check("min_width_cmd", p, 1);
        read_cell(5'd0, c); check("min_width_cell0", c, 8'h37);
        check("min_width_cursor", cursor_addr, 7'h01);

`ifdef LCD_RX_TIMING_CHECK_EN
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("t_rst_err", timing_err, 8'h00);
        wr(1'b0, 8'h0C);
        check("t_first_err", timing_err, 8'h00);
        repeat (86) @(negedge clk);
        wr(1'b0, 8'h0C);
        check("t_short_gap_err", timing_err, 8'h01);
        repeat (2500) @(negedge clk);
        wr(1'b1, 8'h21);
        check("t_long_gap_err", timing_err, 8'h01);
`else
        check("timing_err_tied", timing_err, 8'h00);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
